// File: rtl/counter_bank_uart_dump.sv
// Dumps a bank of 16 x 16-bit counters as 100 ASCII characters over an 8N1 UART.
// Latency: the first start bit goes out 17 clocks after start; there are 17 idle clocks between slots.
// Backpressure: none; start is ignored unless the FSM is idle.
module counter_bank_uart_dump #(
    parameter int CLK_HZ       = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] data_raw,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CONVERT, SEND, NEXT} state_t;

    state_t        state_q, state_d;
    logic [255:0]  snap_q, snap_d;     // slot being sent always sits in the top 16 bits
    logic [3:0]    slot_q, slot_d;
    logic [15:0]   bin_q, bin_d;       // binary value being shifted into the BCD digits
    logic [19:0]   bcd_q, bcd_d;       // five BCD digits, most significant in [19:16]
    logic [3:0]    iter_q, iter_d;
    logic [2:0]    chr_q, chr_d;       // 0..4 digits, 5 space/CR, 6 LF
    logic [3:0]    bit_q, bit_d;       // 0 start, 1..8 data, 9 stop
    logic [CW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          line_end;
    logic [2:0]    chr_last;
    logic [7:0]    chr_byte;
    logic [19:0]   bcd_adj;

    // Select the byte for the current character position of the slot.
    always_comb begin
        line_end = (slot_q[1:0] == 2'd3);
        chr_last = line_end ? 3'd6 : 3'd5;
        case (chr_q)
            3'd0:    chr_byte = {4'h3, bcd_q[19:16]};
            3'd1:    chr_byte = {4'h3, bcd_q[15:12]};
            3'd2:    chr_byte = {4'h3, bcd_q[11:8]};
            3'd3:    chr_byte = {4'h3, bcd_q[7:4]};
            3'd4:    chr_byte = {4'h3, bcd_q[3:0]};
            3'd5:    chr_byte = line_end ? 8'h0D : 8'h20;
            default: chr_byte = 8'h0A;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic for the dump sequencer, converter and UART framer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        slot_d  = slot_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        chr_d   = chr_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    snap_d  = data_raw;
                    slot_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bin_d   = snap_q[255:240];
                bcd_d   = 20'd0;
                iter_d  = 4'd0;
                state_d = CONVERT;
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    chr_d   = 3'd0;
                    bit_d   = 4'd0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (baud_q != BAUD_LAST) begin
                    baud_d = baud_q + 1'b1;
                end else begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (chr_q == chr_last) begin
                            tx_d    = 1'b1;
                            state_d = NEXT;
                            if (slot_q == 4'd15) begin
                                done_d = 1'b1;
                                busy_d = 1'b0;
                            end
                        end else begin
                            // Next frame starts immediately after the stop bit.
                            chr_d = chr_q + 3'd1;
                            tx_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : chr_byte[bit_q[2:0]];
                    end
                end
            end
            NEXT: begin
                if (slot_q == 4'd15) begin
                    state_d = IDLE;
                end else begin
                    slot_d  = slot_q + 4'd1;
                    snap_d  = snap_q << 16;
                    bin_d   = snap_q[239:224];
                    bcd_d   = 20'd0;
                    iter_d  = 4'd0;
                    state_d = CONVERT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the line idle and aborts any dump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            slot_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            chr_q   <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            slot_q  <= slot_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            chr_q   <= chr_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_bank_uart_dump.sv
// Scoreboard bench for counter_bank_uart_dump: expected characters are queued at stimulus time.
// A UART monitor decodes tx, checks the waveform cycle-by-cycle and the inter-frame gaps.
// A done monitor checks the pulse width, busy alignment and placement after the final stop bit.
module tb_counter_bank_uart_dump;
    localparam int CPB   = 6;
    localparam int FRAME = 10 * CPB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] data_raw;
    logic         tx;
    logic         busy;
    logic         done;

    counter_bank_uart_dump #(
        .CLK_HZ      (600),
        .BAUD        (100),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_raw(data_raw),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    // kind: 0 first char of a dump, 1 must follow back-to-back, 2 first char of a later slot
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] ch;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int last_stop_cyc = -10;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d, want <= %0d", name, act, lim);
        end
    endtask

    function automatic logic [255:0] mk(input int seed);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) d[255-16*k -: 16] = 16'((seed * (k + 1) + k * 7) % 65536);
        return d;
    endfunction

    // Queue the 100 characters one dump of d must produce.
    task automatic push_dump(input logic [255:0] d);
        int v;
        int p;
        exp_t e;
        for (int s = 0; s < 16; s++) begin
            v = int'(d[255-16*s -: 16]);
            p = 10000;
            for (int i = 0; i < 5; i++) begin
                e.ch   = 8'h30 + 8'((v / p) % 10);
                e.kind = (i != 0) ? 2'd1 : ((s == 0) ? 2'd0 : 2'd2);
                exp_q.push_back(e);
                p = p / 10;
            end
            e.kind = 2'd1;
            if (s % 4 == 3) begin
                e.ch = 8'h0D; exp_q.push_back(e);
                e.ch = 8'h0A; exp_q.push_back(e);
            end else begin
                e.ch = 8'h20; exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(done === 1'b1), 1);
    endtask

    task automatic wait_chars(input string name, input int cnt);
        int n;
        n = 0;
        while (rx_cnt < cnt && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(rx_cnt >= cnt), 1);
    endtask

    task automatic idle_check(input string name, input int ncyc);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx !== 1'b1) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic dump_end_checks(input string tag, input int want_done);
        @(negedge clk);
        chk({tag, "_chars"}, rx_cnt, 100);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_done_count"}, done_cnt, want_done);
    endtask

    // UART monitor: decode every frame on tx and compare with the scoreboard queue.
    initial begin : uart_mon
        int idle;
        int idle_s;
        int b;
        logic [7:0] rxb;
        logic ebit;
        exp_t e;
        bit have;
        bit fbad;
        bit abort;
        idle = 0;
        e = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idle = 0;
                continue;
            end
            if (tx === 1'b1) begin
                idle++;
                continue;
            end
            rx_cnt++;
            idle_s = idle;
            have = (exp_q.size() > 0);
            if (have) e = exp_q.pop_front();
            fbad  = 1'b0;
            abort = 1'b0;
            rxb   = 8'h00;
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clk);
                if (reset) begin
                    abort = 1'b1;
                    break;
                end
                b = c / CPB;
                if (b >= 1 && b <= 8 && (c % CPB) == CPB / 2) rxb[b-1] = tx;
                ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.ch[b-1];
                if (have && tx !== ebit) fbad = 1'b1;
                if (c == FRAME - 1) last_stop_cyc = cyc;
            end
            idle = 0;
            if (!abort) begin
                chk("char_expected", int'(have), 1);
                if (have) begin
                    chk("char_value", int'(rxb), int'(e.ch));
                    chk("frame_waveform", int'(fbad), 0);
                    if (e.kind == 2'd1) chk("inslot_gap", idle_s, 0);
                    if (e.kind == 2'd2) chk_le("slot_gap", idle_s, 20);
                end
            end
        end
    end

    // Done monitor: one-cycle pulse, busy drops with it, right after the last stop bit.
    initial begin : done_mon
        logic prev_done;
        logic prev_busy;
        prev_done = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && done === 1'b1) begin
                done_cnt++;
                chk("done_busy_low", int'(busy), 0);
                chk("busy_before_done", int'(prev_busy), 1);
                chk("done_width", int'(prev_done), 0);
                chk("done_after_stop", cyc, last_stop_cyc + 1);
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #(10 * 95000);
        total++;
        bad++;
        $display("FAIL watchdog: cycle budget exhausted");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [255:0] d;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        data_raw = '0;
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_check("idle_tx_after_reset", 40);

        // All-zero bank, plus first-start-bit latency.
        rx_cnt = 0;
        data_raw = '0;
        push_dump('0);
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        n = 1;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_le("first_start_latency", n, 20);
        wait_done("zeros_done");
        dump_end_checks("zeros", 1);

        // Boundary values: 65535, 1234 and 7 among zeros.
        d = '0;
        d[255:240] = 16'd65535;
        d[175:160] = 16'd1234;
        d[15:0]    = 16'd7;
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        pulse_start();
        wait_done("edges_done");
        dump_end_checks("edges", 2);

        // Input changes after start must not reach the dump.
        d = mk(997);
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        pulse_start();
        repeat (9) @(negedge clk);
        data_raw = '1;
        wait_done("snapshot_done");
        dump_end_checks("snapshot", 3);

        // Start while busy is ignored; start on done ignored; start one cycle later accepted.
        d = mk(3001);
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        pulse_start();
        wait_chars("reach_char40", 40);
        pulse_start();
        chk("busy_held_mid_dump", int'(busy), 1);
        wait_done("busy_start_done");
        chk("busy_start_chars", rx_cnt, 100);
        chk("busy_start_queue_left", exp_q.size(), 0);
        d = mk(40503);
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        start = 1'b1;
        @(negedge clk);
        chk("start_on_done_ignored", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_start_done_count", done_cnt, 4);
        @(negedge clk);
        chk("start_after_done_accepted", int'(busy), 1);
        start = 1'b0;
        wait_done("second_dump_done");
        dump_end_checks("second", 5);

        // Reset during data bit 3 of char 50 aborts without done; a fresh dump then works.
        d = mk(12345);
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        pulse_start();
        wait_chars("reach_char50", 50);
        repeat (4 * CPB + 1) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_tx", int'(tx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, 5);
        reset = 1'b0;
        idle_check("idle_tx_after_abort", 30);
        d = mk(59999);
        d[255:240] = 16'd10000;
        rx_cnt = 0;
        data_raw = d;
        push_dump(d);
        pulse_start();
        wait_done("post_reset_done");
        dump_end_checks("post_reset", 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
